freq_meas_seq: RTL and testbench

- Sequencer for the reciprocal-counting frequency-meter datapath.
- Generates a programmable gate request, waits for the datapath's edge-synchronised measurement to close, captures the clock and square counts, and presents them on a valid/ready result port.
- Adds single-shot and continuous modes, plus a no-signal timeout.
- Sits between the register/control logic and the counting core, all on the 6 MHz system clock.

---
 rtl/freq_meas_pkg.sv | 23 ++
 rtl/freq_gate_timer.sv | 31 +++
 rtl/freq_meas_seq.sv | 211 +++++++++++++++++++++
 tb/tb_freq_meas_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// Shared types and default timing constants for the frequency-meter sequencer.
package freq_meas_pkg;

  localparam int CNT_W = 28;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GUARD  = 3'd1,
    ST_GATE   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Gate lengths are stored as (cycles - 1) of the 6 MHz clock
  localparam logic [CNT_W-1:0] DEF_GATE_T0     = 28'd5_999;
  localparam logic [CNT_W-1:0] DEF_GATE_T1     = 28'd59_999;
  localparam logic [CNT_W-1:0] DEF_GATE_T2     = 28'd599_999;
  localparam logic [CNT_W-1:0] DEF_GATE_T3     = 28'd5_999_999;
  localparam logic [CNT_W-1:0] DEF_TIMEOUT_CYC = 28'd6_000_000;
  localparam int               DEF_GUARD_CYC   = 4;
  localparam logic [CNT_W-1:0] DEF_MIN_SQU     = 28'd1000;

endpackage

// File: rtl/freq_gate_timer.sv
// Loadable down counter with terminal-count flag; shared by the guard, gate
// and timeout phases of the sequencer.
module freq_gate_timer
  import freq_meas_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;

  // Reload has priority over decrement; the count parks at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/freq_meas_seq.sv
// Reciprocal-counting frequency-meter sequencer: gate generation, result capture
// with timeout, single/continuous modes. Define FREQ_AUTORANGE_EN for autoranging.
module freq_meas_seq
  import freq_meas_pkg::*;
#(
  parameter logic [CNT_W-1:0] GATE_T0     = DEF_GATE_T0,
  parameter logic [CNT_W-1:0] GATE_T1     = DEF_GATE_T1,
  parameter logic [CNT_W-1:0] GATE_T2     = DEF_GATE_T2,
  parameter logic [CNT_W-1:0] GATE_T3     = DEF_GATE_T3,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
`ifdef FREQ_AUTORANGE_EN
  parameter logic [CNT_W-1:0] MIN_SQU     = DEF_MIN_SQU,
`endif
  parameter int               GUARD_CYC   = DEF_GUARD_CYC
) (
  input  logic             clk_6M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [1:0]       gate_sel,
  output logic             gate,
  input  logic             core_done,
  input  logic [CNT_W-1:0] core_cntclk,
  input  logic [CNT_W-1:0] core_cntsqu,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cntclk,
  output logic [CNT_W-1:0] res_cntsqu,
  output logic             res_timeout,
  output logic [1:0]       res_gsel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = TIMEOUT_CYC - 28'd1;

  state_t           state;
  logic [1:0]       sel_r;
  logic             t_load;
  logic             t_dec;
  logic [CNT_W-1:0] t_val;
  logic             t_tc;
  logic             retry;
  logic             xfer;

  function automatic logic [CNT_W-1:0] gate_len(input logic [1:0] s);
    case (s)
      2'd0:    gate_len = GATE_T0;
      2'd1:    gate_len = GATE_T1;
      2'd2:    gate_len = GATE_T2;
      2'd3:    gate_len = GATE_T3;
      default: gate_len = GATE_T3;
    endcase
  endfunction

`ifdef FREQ_AUTORANGE_EN
  // Too few square periods in this range: step to the next longer gate
  assign retry = (core_cntsqu < MIN_SQU) && (sel_r != 2'd3);
`else
  assign retry = 1'b0;
`endif

  assign xfer = res_valid & res_ready;

  // Timer control: reload at every phase entry, otherwise count down
  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = GUARD_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          t_load = 1'b1;
          t_val  = GUARD_LOAD;
        end else begin
          t_load = 1'b0;
        end
      end
      ST_GUARD: begin
        if (t_tc) begin
          t_load = 1'b1;
          t_val  = gate_len(sel_r);
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_GATE: begin
        if (t_tc) begin
          t_load = 1'b1;
          t_val  = TIMEOUT_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          t_load = 1'b1;
          t_val  = GUARD_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_RESULT: begin
        if (xfer) begin
          t_load = 1'b1;
          t_val  = GUARD_LOAD;
        end else begin
          t_dec = 1'b0;
        end
      end
      default: begin
        t_load = 1'b0;
      end
    endcase
  end

  freq_gate_timer u_timer (
    .clk      (clk_6M),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .tc       (t_tc)
  );

  // Sequencer state machine with registered outputs
  always_ff @(posedge clk_6M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel_r       <= 2'd0;
      gate        <= 1'b0;
      res_valid   <= 1'b0;
      res_cntclk  <= {CNT_W{1'b0}};
      res_cntsqu  <= {CNT_W{1'b0}};
      res_timeout <= 1'b0;
      res_gsel    <= 2'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_r <= gate_sel;
            busy  <= 1'b1;
            state <= ST_GUARD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GUARD: begin
          if (t_tc) begin
            gate  <= 1'b1;
            state <= ST_GATE;
          end else begin
            state <= ST_GUARD;
          end
        end
        ST_GATE: begin
          if (t_tc) begin
            gate  <= 1'b0;
            state <= ST_WAIT;
          end else begin
            state <= ST_GATE;
          end
        end
        ST_WAIT: begin
          // A done pulse on the last wait cycle beats the timeout
          if (core_done && retry) begin
            sel_r <= sel_r + 2'd1;
            state <= ST_GUARD;
          end else if (core_done) begin
            res_cntclk  <= core_cntclk;
            res_cntsqu  <= core_cntsqu;
            res_timeout <= 1'b0;
            res_gsel    <= sel_r;
            res_valid   <= 1'b1;
            state       <= ST_RESULT;
          end else if (t_tc) begin
            res_cntclk  <= {CNT_W{1'b0}};
            res_cntsqu  <= {CNT_W{1'b0}};
            res_timeout <= 1'b1;
            res_gsel    <= sel_r;
            res_valid   <= 1'b1;
            state       <= ST_RESULT;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_RESULT: begin
          if (xfer) begin
            res_valid <= 1'b0;
            if (cont) begin
              state <= ST_GUARD;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            state <= ST_RESULT;
          end
        end
        default: begin
          gate      <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_seq.sv
// Self-checking bench for freq_meas_seq: vector table, random measurements
// against a spec-level timing model, plus reset and stale-pulse sequences.
module tb_freq_meas_seq;
  import freq_meas_pkg::*;

  localparam logic [27:0] T0    = 28'd5_999;
  localparam logic [27:0] T1    = 28'd199;
  localparam logic [27:0] T2    = 28'd49;
  localparam logic [27:0] T3    = 28'd9;
  localparam logic [27:0] TMO   = 28'd100;
  localparam int          GUARD = 4;

  logic        clk_6M = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [1:0]  gate_sel = 2'd0;
  logic        gate;
  logic        core_done = 1'b0;
  logic [27:0] core_cntclk = 28'd0;
  logic [27:0] core_cntsqu = 28'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [27:0] res_cntclk;
  logic [27:0] res_cntsqu;
  logic        res_timeout;
  logic [1:0]  res_gsel;
  logic        busy;

  freq_meas_seq #(
    .GATE_T0     (T0),
    .GATE_T1     (T1),
    .GATE_T2     (T2),
    .GATE_T3     (T3),
    .TIMEOUT_CYC (TMO),
    .GUARD_CYC   (GUARD)
  ) dut (
    .clk_6M      (clk_6M),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .gate_sel    (gate_sel),
    .gate        (gate),
    .core_done   (core_done),
    .core_cntclk (core_cntclk),
    .core_cntsqu (core_cntsqu),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_cntclk  (res_cntclk),
    .res_cntsqu  (res_cntsqu),
    .res_timeout (res_timeout),
    .res_gsel    (res_gsel),
    .busy        (busy)
  );

  always #5 clk_6M = ~clk_6M;

  typedef struct {
    bit          do_start;
    logic [1:0]  sel;
    bit          resp;
    int          delay;
    logic [27:0] cc;
    logic [27:0] cs;
    int          rdly;
    bit          cont;
    bit          inject;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] cur_sel = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gate_high(input logic [1:0] s);
    case (s)
      2'd0:    return int'(T0) + 1;
      2'd1:    return int'(T1) + 1;
      2'd2:    return int'(T2) + 1;
      default: return int'(T3) + 1;
    endcase
  endfunction

  // One measurement: arm (or ride continuous re-arm), core response, handshake
  task automatic run_meas(input vec_t v);
    int          n;
    int          lat;
    bit          tmo_exp;
    bit          stable;
    logic [27:0] ecc;
    logic [27:0] ecs;
    cont      = v.cont;
    res_ready = (v.rdly == 0);
    if (v.do_start) begin
      cur_sel  = v.sel;
      gate_sel = v.sel;
      start    = 1'b1;
      @(negedge clk_6M);
      start    = 1'b0;
      gate_sel = ~v.sel;
    end
    n = 0;
    while (!gate && n < 64) begin
      n++;
      @(negedge clk_6M);
    end
    chk("guard_low", n, GUARD);
    n = 0;
    while (gate && n < 7000) begin
      if (v.inject && n == 3) begin
        start     = 1'b1;
        core_done = 1'b1;
      end else begin
        start     = 1'b0;
        core_done = 1'b0;
      end
      n++;
      @(negedge clk_6M);
    end
    start     = 1'b0;
    core_done = 1'b0;
    chk("gate_high", n, gate_high(cur_sel));
    core_cntclk = v.cc;
    core_cntsqu = v.cs;
    core_done   = v.resp && (v.delay == 0);
    lat = 0;
    while (lat < int'(TMO) + 20) begin
      @(negedge clk_6M);
      lat++;
      core_done = 1'b0;
      if (res_valid) break;
      if (v.resp && v.delay == lat) core_done = 1'b1;
    end
    core_done = 1'b0;
    tmo_exp = !(v.resp && v.delay < int'(TMO));
    ecc = tmo_exp ? 28'd0 : v.cc;
    ecs = tmo_exp ? 28'd0 : v.cs;
    chk("latency", lat, tmo_exp ? int'(TMO) : v.delay + 1);
    chk("res_timeout", res_timeout, tmo_exp);
    chk("res_cntclk", res_cntclk, ecc);
    chk("res_cntsqu", res_cntsqu, ecs);
    chk("res_gsel", res_gsel, cur_sel);
    chk("busy_result", busy, 1);
    stable = 1'b1;
    for (int i = 0; i < v.rdly; i++) begin
      if (!res_valid || res_cntclk !== ecc || res_cntsqu !== ecs ||
          res_timeout !== tmo_exp || res_gsel !== cur_sel) stable = 1'b0;
      @(negedge clk_6M);
    end
    if (!res_valid || res_cntclk !== ecc || res_cntsqu !== ecs) stable = 1'b0;
    res_ready = 1'b1;
    @(negedge clk_6M);
    if (v.rdly > 0) chk("hold_stable", stable, 1);
    chk("xfer_valid_low", res_valid, 0);
    chk("busy_after_xfer", busy, v.cont);
    res_ready = 1'b0;
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t rv;
    int   seen;

    vecs[0] = '{1'b1, 2'd0, 1'b1, 37,  28'd6000,   28'd1000, 0,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 1'b1, 5,   28'd12345,  28'd678,  50, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 1'b0, 0,   28'd999,    28'd999,  3,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 99,  28'd4242,   28'd17,   0,  1'b0, 1'b1};
    vecs[4] = '{1'b1, 2'd3, 1'b1, 100, 28'd777,    28'd77,   1,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 1'b1, 10,  28'd201,    28'd301,  0,  1'b1, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 1'b1, 20,  28'd202,    28'd302,  2,  1'b1, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 1'b1, 0,   28'd203,    28'd303,  1,  1'b0, 1'b0};

    repeat (3) @(negedge clk_6M);
    chk("rst_gate", gate, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_cntclk", res_cntclk, 0);
    chk("rst_cntsqu", res_cntsqu, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_gsel", res_gsel, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk_6M);

    for (int i = 0; i < 8; i++) run_meas(vecs[i]);

    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || res_valid || gate) seen++;
      @(negedge clk_6M);
    end
    chk("idle_after_cont_drop", seen, 0);

    // Reset in the middle of a gate, then a stale done pulse
    gate_sel = 2'd1;
    start    = 1'b1;
    @(negedge clk_6M);
    start = 1'b0;
    seen = 0;
    while (!gate && seen < 64) begin
      seen++;
      @(negedge clk_6M);
    end
    repeat (20) @(negedge clk_6M);
    chk("pre_rst_gate", gate, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gate", gate, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cntclk", res_cntclk, 0);
    @(negedge clk_6M);
    rst_n     = 1'b1;
    core_done = 1'b1;
    @(negedge clk_6M);
    core_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (res_valid || gate || busy) seen++;
      @(negedge clk_6M);
    end
    chk("stale_done_ignored", seen, 0);

    for (int i = 0; i < 8; i++) begin
      rv.do_start = 1'b1;
      rv.sel      = 2'($urandom_range(0, 3));
      rv.resp     = ($urandom_range(0, 3) != 0);
      rv.delay    = int'($urandom_range(0, 110));
      rv.cc       = 28'($urandom);
      rv.cs       = 28'($urandom);
      rv.rdly     = int'($urandom_range(0, 4));
      rv.cont     = 1'b0;
      rv.inject   = ($urandom_range(0, 1) == 1);
      run_meas(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
